ola_recorder: RTL and testbench
===============================

Name: ola_recorder

Overview:
- Consumer end of the trigger stage's valid/sample/trigger stream.
- Records the stream into a circular sample buffer while armed and keeps pre-trigger history.
- On trigger, captures a programmed number of post-trigger samples, then stops.
- Plays the capture back oldest-first over a valid/ready readout port toward the host interface.

Parameters:
- sample_width, 8, width of each sample word
- addr_width, 4, buffer address width; depth = 2**addr_width

Ports:
- clock  input  1  system clock; all logic rising-edge
- reset  input  1  synchronous, active-high reset
- ctl_arm  input  1  pulse: start capture (honoured only in IDLE)
- ctl_abort  input  1  pulse: return to IDLE from any state
- ctl_post_count  input  addr_width  post-trigger samples to record, latched at trigger
- in_valid  input  1  sample strobe from trigger stage
- in_sample  input  sample_width  sample data
- in_trigger  input  1  trigger flag, qualified by in_valid
- rd_valid  output  1  rd_data holds a captured word
- rd_ready  input  1  host accepts word
- rd_data  output  sample_width  captured sample
- rd_last  output  1  rd_data is the final (newest) word
- status_state  output  2  0=IDLE 1=ARMED 2=POST 3=READ
- status_fill  output  addr_width+1  words currently held, saturating at depth

Behaviour:
- Reset, synchronous, active-high: state IDLE; wr_ptr, fill, post_left and read counters cleared. Outputs after reset: rd_valid=0, rd_last=0, rd_data=0, status_fill=0. Memory contents are don't-care.
- Reset and ctl_abort override everything, including a transfer in flight. ctl_abort with ctl_arm in the same cycle: abort wins.
- IDLE:
  - in_* ignored.
  - ctl_arm → ARMED next cycle, with wr_ptr=0 and fill=0.
- ARMED:
  - Each in_valid writes in_sample to mem[wr_ptr]; wr_ptr increments and wraps at depth; fill increments, saturating at depth.
  - in_valid with in_trigger: the triggering sample is written, and ctl_post_count is latched into post_left.
  - If the latched value is 0 → READ; otherwise → POST.
  - in_trigger without in_valid is ignored.
- POST:
  - Each in_valid writes as in ARMED and decrements post_left; after the write that makes post_left 0 → READ.
  - in_trigger is ignored.
  - Samples arriving in READ or IDLE are dropped.
- READ:
  - Oldest address = wr_ptr − fill, modulo depth; word count = fill.
  - Memory read is synchronous with one-word prefetch. First rd_valid is asserted exactly 2 cycles after entering READ.
  - Handshake: a word transfers when rd_valid && rd_ready.
  - rd_valid, rd_data and rd_last are held stable while rd_ready=0.
  - Back-to-back transfers at one word/cycle when rd_ready is held high.
  - rd_last=1 only with the fill-th word.
  - The cycle after the last transfer: rd_valid=0, state IDLE, status_fill keeps its final value until the next arm.
- Wrap: once fill saturates, the oldest word is overwritten; readout then begins at wr_ptr.
- ctl_post_count ≥ depth−1 is legal: the buffer then holds only the newest depth words.
- status_state and status_fill are registered and track the current state and fill.

Optional Feature:
- Macro: OLA_RECORDER_TRIGGER_MARK_EN.
- Defined:
  - Memory is sample_width+1 bits wide and stores in_trigger alongside each sample.
  - Extra output port rd_trigger (1 bit) follows rd_data timing and is 1 only for the triggering word.
  - Reset value of rd_trigger is 0.
- Undefined: no extra memory bit and no rd_trigger port; all other behaviour is identical.

Test Plan:
- Basic capture (depth 16):
  - Stimulus: arm; feed 0x00..0x09 with trigger on 0x05; post_count=3.
  - Required: state ARMED→POST→READ after 0x08; readout 0x00..0x08, 9 words, rd_last on 0x08; 0x09 not recorded; status_fill=9.
- Wrap-around:
  - Stimulus: arm; feed 0x00..0x1F with no trigger; trigger on 0x20; post_count=2.
  - Required: 16 words read, 0x13..0x22; rd_last on 0x22; with MARK_EN, rd_trigger=1 on 0x20 only.
- Zero post count:
  - Stimulus: feed 0x00..0x02, trigger on 0x03; post_count=0.
  - Required: READ the cycle after 0x03; readout 0x00..0x03, 4 words; first rd_valid 2 cycles after entering READ.
- Backpressure:
  - Stimulus: 9-word capture; rd_ready toggled 1,0,0,1,…
  - Required: every word appears exactly once, in order; rd_data and rd_last stable while stalled.
- Abort and re-arm:
  - Stimulus: ctl_abort mid-POST.
  - Required: IDLE next cycle; rd_valid=0; later samples ignored; a re-arm captures a fresh buffer with status_fill restarting from 0.
- Reset mid-readout:
  - Stimulus: reset asserted for 1 cycle during READ with rd_ready=0.
  - Required: next cycle rd_valid=0, rd_last=0, status_state=0, status_fill=0; ctl_arm is accepted afterwards.

Source files
------------

// File: rtl/ola_recorder_if.sv
// ola_recorder_if
//   Stream bundle around the recorder: the sample stream arriving from the
//   trigger stage and the readout stream leaving towards the host interface.
//
//   Signals:
//     in_valid / in_sample / in_trigger : sample strobe, data, trigger flag
//     rd_valid / rd_ready / rd_data / rd_last : readout stream
//     rd_trigger : marks the triggering word (only with OLA_RECORDER_TRIGGER_MARK_EN)
//
//   Modports:
//     master : the environment (drives in_* and rd_ready)
//     slave  : the recorder (consumes in_*, drives rd_*)
//
//   Optional feature macro: OLA_RECORDER_TRIGGER_MARK_EN adds rd_trigger.
interface ola_recorder_if #(
  parameter int sample_width = 8
);
  logic                    in_valid;
  logic [sample_width-1:0] in_sample;
  logic                    in_trigger;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [sample_width-1:0] rd_data;
  logic                    rd_last;
`ifdef OLA_RECORDER_TRIGGER_MARK_EN
  logic                    rd_trigger;

  modport master (
    output in_valid, in_sample, in_trigger, rd_ready,
    input  rd_valid, rd_data, rd_last, rd_trigger
  );
  modport slave (
    input  in_valid, in_sample, in_trigger, rd_ready,
    output rd_valid, rd_data, rd_last, rd_trigger
  );
`else
  modport master (
    output in_valid, in_sample, in_trigger, rd_ready,
    input  rd_valid, rd_data, rd_last
  );
  modport slave (
    input  in_valid, in_sample, in_trigger, rd_ready,
    output rd_valid, rd_data, rd_last
  );
`endif
endinterface

// File: rtl/ola_recorder.sv
// ola_recorder
//   Logic-analyser capture buffer. While armed, every valid sample goes into a
//   circular buffer so pre-trigger history is kept. A qualified trigger latches
//   the post-trigger count; once that many further samples are stored the
//   recorder stops and plays the buffer back oldest-first.
//
//   Ports:
//     clock, reset        : rising-edge clock, synchronous active-high reset
//     ctl_arm             : pulse, start a capture (only from IDLE)
//     ctl_abort           : pulse, back to IDLE from any state (beats ctl_arm)
//     ctl_post_count      : post-trigger sample count, latched at trigger
//     bus (slave)         : in_* sample stream in, rd_* readout stream out
//     status_state        : 0=IDLE 1=ARMED 2=POST 3=READ (the state register)
//     status_fill         : words currently held, saturating at depth
//
//   Optional feature macro: OLA_RECORDER_TRIGGER_MARK_EN stores the trigger
//   flag beside each sample and returns it on bus.rd_trigger.
//
//   Readout handshake: a word moves when rd_valid && rd_ready at a rising edge.
//   Once rd_valid is high, rd_valid/rd_data/rd_last stay unchanged until that
//   transfer happens; rd_valid never depends combinationally on rd_ready.
module ola_recorder #(
  parameter int sample_width = 8,
  parameter int addr_width   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctl_arm,
  input  logic                  ctl_abort,
  input  logic [addr_width-1:0] ctl_post_count,
  ola_recorder_if.slave         bus,
  output logic [1:0]            status_state,
  output logic [addr_width:0]   status_fill
);
  localparam int depth = 2 ** addr_width;
`ifdef OLA_RECORDER_TRIGGER_MARK_EN
  localparam int mem_width = sample_width + 1;
`else
  localparam int mem_width = sample_width;
`endif
  localparam logic [addr_width:0]   fill_max = (addr_width + 1)'(depth);
  localparam logic [addr_width:0]   one_f    = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] one_a    = addr_width'(1);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_armed = 2'd1,
    st_post  = 2'd2,
    st_read  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [addr_width-1:0] wr_ptr, wr_ptr_nxt;
  logic [addr_width:0]   fill, fill_nxt;
  logic [addr_width-1:0] post_left;
  logic                  wr_en, trig_hit, enter_read;
  logic [mem_width-1:0]  wr_word;

  logic [mem_width-1:0]  mem [depth];
  logic [mem_width-1:0]  mem_q;
  logic [addr_width-1:0] rd_addr;
  logic [addr_width:0]   issue_left;
  logic                  q_valid, q_last;
  logic                  out_free, move_q, issue;

  // Write side: only ARMED/POST record, and an abort suppresses the write.
  always_comb begin
    wr_en      = 1'b0;
    if (!ctl_abort && (state == st_armed || state == st_post)) wr_en = bus.in_valid;
    trig_hit   = wr_en && (state == st_armed) && bus.in_trigger;
    wr_ptr_nxt = wr_en ? wr_ptr + one_a : wr_ptr;
    fill_nxt   = fill;
    if (wr_en && fill != fill_max) fill_nxt = fill + one_f;
  end

`ifdef OLA_RECORDER_TRIGGER_MARK_EN
  assign wr_word = {trig_hit, bus.in_sample};
`else
  assign wr_word = bus.in_sample;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      st_idle:  if (ctl_arm) state_nxt = st_armed;
      st_armed: if (trig_hit) state_nxt = (ctl_post_count == '0) ? st_read : st_post;
      st_post:  if (wr_en && post_left == one_a) state_nxt = st_read;
      st_read:  if (bus.rd_valid && bus.rd_ready && bus.rd_last) state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
    if (ctl_abort) state_nxt = st_idle;
  end

  assign enter_read = (state != st_read) && (state_nxt == st_read);

  // Two-stage read pipe: mem_q is the prefetched word, rd_* the output stage.
  // A new address is issued whenever the prefetch slot is (or is becoming) empty.
  assign out_free = !bus.rd_valid || bus.rd_ready;
  assign move_q   = (state == st_read) && q_valid && out_free;
  assign issue    = (state == st_read) && (issue_left != '0) && (!q_valid || out_free);

  always_ff @(posedge clock) begin
    if (reset) state <= st_idle;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
    if (issue) mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      fill         <= '0;
      post_left    <= '0;
      rd_addr      <= '0;
      issue_left   <= '0;
      q_valid      <= 1'b0;
      q_last       <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
      bus.rd_data  <= '0;
`ifdef OLA_RECORDER_TRIGGER_MARK_EN
      bus.rd_trigger <= 1'b0;
`endif
    end else begin
      if (state == st_idle && ctl_arm && !ctl_abort) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else begin
        wr_ptr <= wr_ptr_nxt;
        fill   <= fill_nxt;
      end

      if (trig_hit)                        post_left <= ctl_post_count;
      else if (wr_en && state == st_post)  post_left <= post_left - one_a;

      if (ctl_abort) begin
        issue_left   <= '0;
        q_valid      <= 1'b0;
        q_last       <= 1'b0;
        bus.rd_valid <= 1'b0;
        bus.rd_last  <= 1'b0;
`ifdef OLA_RECORDER_TRIGGER_MARK_EN
        bus.rd_trigger <= 1'b0;
`endif
      end else begin
        // Oldest word sits fill places behind the write pointer; with a full
        // buffer the low bits of fill are zero, so that is wr_ptr itself.
        if (enter_read) begin
          rd_addr    <= wr_ptr_nxt - fill_nxt[addr_width-1:0];
          issue_left <= fill_nxt;
        end else if (issue) begin
          rd_addr    <= rd_addr + one_a;
          issue_left <= issue_left - one_f;
        end

        if (issue)       q_valid <= 1'b1;
        else if (move_q) q_valid <= 1'b0;
        if (issue)       q_last  <= (issue_left == one_f);

        if (move_q) begin
          bus.rd_valid <= 1'b1;
          bus.rd_data  <= mem_q[sample_width-1:0];
          bus.rd_last  <= q_last;
`ifdef OLA_RECORDER_TRIGGER_MARK_EN
          bus.rd_trigger <= mem_q[sample_width];
`endif
        end else if (bus.rd_valid && bus.rd_ready) begin
          bus.rd_valid <= 1'b0;
          bus.rd_last  <= 1'b0;
`ifdef OLA_RECORDER_TRIGGER_MARK_EN
          bus.rd_trigger <= 1'b0;
`endif
        end
      end
    end
  end

  assign status_state = state;
  assign status_fill  = fill;
endmodule

// File: tb/tb_ola_recorder.sv
// tb_ola_recorder
//   Directed bench for ola_recorder. A queue model keeps the newest depth
//   recorded samples and a small state tracker follows the capture rules; the
//   readout stream is scored against that queue on every transfer cycle.
module tb_ola_recorder;
  localparam int sw     = 8;
  localparam int aw     = 4;
  localparam int depth  = 16;
  localparam int budget = 200;
  localparam int s_idle = 0, s_armed = 1, s_post = 2, s_read = 3;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ctl_arm = 1'b0;
  logic          ctl_abort = 1'b0;
  logic [aw-1:0] ctl_post_count = '0;
  logic [1:0]    status_state;
  logic [aw:0]   status_fill;

  always #5 clock = ~clock;

  ola_recorder_if #(.sample_width(sw)) bus ();

  ola_recorder #(.sample_width(sw), .addr_width(aw)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctl_arm        (ctl_arm),
    .ctl_abort      (ctl_abort),
    .ctl_post_count (ctl_post_count),
    .bus            (bus),
    .status_state   (status_state),
    .status_fill    (status_fill)
  );

  // ---------------- model / scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          m_state = s_idle;
  int          m_post = 0;
  logic [sw:0] m_buf[$];
  logic [sw:0] exp_q[$];
  int          xfer_cnt = 0;
  logic [sw-1:0] first_word = '0;
  logic [sw-1:0] last_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- compare process ----------------
  logic          p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_rst = 1'b1, p_lastx = 1'b0;
  logic [sw-1:0] p_data = '0;
  logic [sw:0]   w;

  always @(negedge clock) begin
    if (!reset && p_lastx) begin
      chk("after_last_state", status_state, 0);
      chk("after_last_valid", bus.rd_valid, 0);
    end
    if (!reset && !p_rst && p_valid && !p_ready) begin
      chk("hold_valid", bus.rd_valid, 1);
      chk("hold_data", bus.rd_data, p_data);
      chk("hold_last", bus.rd_last, p_last);
    end
    p_lastx = 1'b0;
    if (!reset && bus.rd_valid && bus.rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h expected no word", bus.rd_data);
      end else begin
        w = exp_q.pop_front();
        chk("rd_data", bus.rd_data, w[sw-1:0]);
        chk("rd_last", bus.rd_last, exp_q.size() == 0);
`ifdef OLA_RECORDER_TRIGGER_MARK_EN
        chk("rd_trigger", bus.rd_trigger, w[sw]);
`endif
        if (xfer_cnt == 0) first_word = bus.rd_data;
        last_word = bus.rd_data;
        xfer_cnt++;
        p_lastx = (exp_q.size() == 0);
      end
    end
    p_valid = bus.rd_valid;
    p_ready = bus.rd_ready;
    p_data  = bus.rd_data;
    p_last  = bus.rd_last;
    p_rst   = reset || ctl_abort;
  end

  // ---------------- driver tasks ----------------
  task automatic arm();
    ctl_arm = 1'b1;
    step();
    ctl_arm = 1'b0;
    if (m_state == s_idle) begin
      m_state = s_armed;
      m_buf.delete();
    end
    chk("arm_state", status_state, m_state);
    chk("arm_fill", status_fill, m_buf.size());
  endtask

  task automatic abort();
    ctl_abort = 1'b1;
    step();
    ctl_abort = 1'b0;
    m_state = s_idle;
    exp_q.delete();
    chk("abort_state", status_state, 0);
    chk("abort_valid", bus.rd_valid, 0);
  endtask

  task automatic send(input logic [sw-1:0] s, input logic trig);
    bus.in_valid   = 1'b1;
    bus.in_sample  = s;
    bus.in_trigger = trig;
    step();
    bus.in_valid   = 1'b0;
    bus.in_trigger = 1'b0;
    if (m_state == s_armed || m_state == s_post) begin
      m_buf.push_back({trig && (m_state == s_armed), s});
      if (m_buf.size() > depth) m_buf.delete(0);
      if (m_state == s_armed) begin
        if (trig) begin
          m_post  = int'(ctl_post_count);
          m_state = (m_post == 0) ? s_read : s_post;
        end
      end else begin
        m_post--;
        if (m_post == 0) m_state = s_read;
      end
      if (m_state == s_read) exp_q = m_buf;
    end
    chk("status_state", status_state, m_state);
    chk("status_fill", status_fill, m_buf.size());
  endtask

  // k0 = cycles already spent in READ when called; mode 1 = ready 1,0,0,...
  task automatic readout(input int mode, input int k0);
    int k;
    int first_k;
    xfer_cnt = 0;
    first_k  = -1;
    k        = k0;
    while (status_state != 2'd0 && k < budget) begin
      if (bus.rd_valid && first_k < 0) first_k = k;
      bus.rd_ready = (mode == 0) || (k % 3 == 0);
      step();
      k++;
    end
    bus.rd_ready = 1'b0;
    if (status_state != 2'd0) begin
      checks++;
      errors++;
      $display("FAIL readout_timeout: state %0d expected 0", status_state);
    end
    m_state = s_idle;
    chk("first_valid_latency", first_k, 2);
    chk("drain_valid", bus.rd_valid, 0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sample  = '0;
    bus.in_trigger = 1'b0;
    bus.rd_ready   = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset_valid", bus.rd_valid, 0);
    chk("reset_last", bus.rd_last, 0);
    chk("reset_data", bus.rd_data, 0);
    chk("reset_fill", status_fill, 0);
    chk("reset_state", status_state, 0);

    // Basic capture: 0x00..0x08 kept, 0x09 arrives in READ and is dropped.
    ctl_post_count = 4'd3;
    arm();
    for (int i = 0; i < 10; i++) send(8'(i), i == 5);
    readout(0, 1);
    chk("basic_count", xfer_cnt, 9);
    chk("basic_first", first_word, 8'h00);
    chk("basic_last", last_word, 8'h08);
    chk("basic_fill", status_fill, 9);

    // Wrap-around: 35 samples, newest 16 are 0x13..0x22.
    ctl_post_count = 4'd2;
    arm();
    for (int i = 0; i <= 'h22; i++) send(8'(i), i == 'h20);
    readout(0, 0);
    chk("wrap_count", xfer_cnt, 16);
    chk("wrap_first", first_word, 8'h13);
    chk("wrap_last", last_word, 8'h22);
    chk("wrap_fill", status_fill, 16);

    // Zero post count: READ right after the trigger sample.
    ctl_post_count = 4'd0;
    arm();
    for (int i = 0; i < 4; i++) send(8'(i), i == 3);
    chk("zero_state", status_state, 3);
    readout(0, 0);
    chk("zero_count", xfer_cnt, 4);
    chk("zero_first", first_word, 8'h00);
    chk("zero_last", last_word, 8'h03);

    // Backpressure on a 9-word capture.
    ctl_post_count = 4'd3;
    arm();
    for (int i = 0; i < 9; i++) send(8'('h40 + i), i == 5);
    readout(1, 0);
    chk("bp_count", xfer_cnt, 9);
    chk("bp_first", first_word, 8'h40);
    chk("bp_last", last_word, 8'h48);

    // Abort mid-POST, stray samples, then a fresh capture.
    ctl_post_count = 4'd5;
    arm();
    send(8'h50, 1'b0);
    send(8'h51, 1'b1);
    send(8'h52, 1'b0);
    send(8'h53, 1'b0);
    chk("abort_pre_state", status_state, 2);
    abort();
    send(8'h60, 1'b0);
    send(8'h61, 1'b1);
    arm();
    chk("rearm_fill", status_fill, 0);
    ctl_post_count = 4'd0;
    send(8'h70, 1'b0);
    send(8'h71, 1'b1);
    readout(0, 0);
    chk("rearm_count", xfer_cnt, 2);
    chk("rearm_first", first_word, 8'h70);
    chk("rearm_last", last_word, 8'h71);

    // Reset in the middle of a stalled readout.
    ctl_post_count = 4'd0;
    arm();
    send(8'h80, 1'b0);
    send(8'h81, 1'b0);
    send(8'h82, 1'b1);
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("stall_valid", bus.rd_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_state = s_idle;
    m_buf.delete();
    exp_q.delete();
    chk("midrst_valid", bus.rd_valid, 0);
    chk("midrst_last", bus.rd_last, 0);
    chk("midrst_state", status_state, 0);
    chk("midrst_fill", status_fill, 0);
    arm();
    send(8'h90, 1'b1);
    readout(0, 0);
    chk("postrst_count", xfer_cnt, 1);
    chk("postrst_word", last_word, 8'h90);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
